// File: rtl/neuron_mac_sekvencer.sv
// Time-multiplexed hidden-layer neuron evaluator: one shared multiplier, one MAC per clock,
// weights from a synchronous ROM, per-neuron |P-N| magnitude and sign towards the sigmoid LUT.
module neuron_mac_sekvencer #(
  parameter int BROJ_ZNACAJKI = 60,
  parameter int BROJ_NEURONA  = 3,
  parameter int ADR_W         = 8,
  parameter int IDX_W         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [16*BROJ_ZNACAJKI-1:0] uzorak,
  input  logic                       uzorak_valid,
  output logic                       uzorak_ready,
  output logic [ADR_W-1:0]           rom_adresa,
  input  logic [15:0]                rom_podatak,
  output logic [15:0]                mnoz_tezina,
  output logic [15:0]                mnoz_uzorak,
  input  logic [15:0]                mnoz_produkt,
  output logic [21:0]                suma,
  output logic                       predznak,
  output logic [IDX_W-1:0]           neuron_idx,
  output logic                       izlaz_valid,
  input  logic                       izlaz_ready,
  output logic                       zauzet
);

  localparam int                SAMPLE_W  = 16 * BROJ_ZNACAJKI;
  localparam int                K_W       = $clog2(BROJ_ZNACAJKI);
  localparam logic [K_W-1:0]    K_ZADNJI  = K_W'(BROJ_ZNACAJKI - 1);
  localparam logic [K_W-1:0]    K_PREDZAD = K_W'(BROJ_ZNACAJKI - 2);
  localparam logic [IDX_W-1:0]  N_ZADNJI  = IDX_W'(BROJ_NEURONA - 1);
  localparam logic [ADR_W-1:0]  ADR_KORAK = ADR_W'(BROJ_ZNACAJKI);

  typedef enum logic [2:0] {
    MIR       = 3'd0,
    ADR       = 3'd1,
    MAC       = 3'd2,
    USPOREDBA = 3'd3,
    IZLAZ     = 3'd4
  } stanje_e;

  stanje_e               state_q, state_d;
  logic [SAMPLE_W-1:0]   uzorak_q, uzorak_d;
  logic [IDX_W-1:0]      neuron_q, neuron_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [ADR_W-1:0]      adr_q, adr_d;
  logic [15:0]           mnoz_uzorak_q, mnoz_uzorak_d;
  logic [21:0]           p_q, p_d;
  logic [21:0]           n_q, n_d;
  logic [21:0]           suma_q, suma_d;
  logic                  predznak_q, predznak_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  izlaz_valid_q, izlaz_valid_d;
  logic                  uzorak_ready_q, uzorak_ready_d;
  logic                  zauzet_q, zauzet_d;

  function automatic logic [15:0] znacajka(input logic [SAMPLE_W-1:0] u,
                                           input logic [K_W-1:0]      k);
    return u[16*int'(k) +: 16];
  endfunction

  function automatic logic [ADR_W-1:0] adr_baza(input logic [IDX_W-1:0] n);
    return ADR_W'(n) * ADR_KORAK;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= MIR;
      uzorak_q       <= '0;
      neuron_q       <= '0;
      k_q            <= '0;
      adr_q          <= '0;
      mnoz_uzorak_q  <= 16'd0;
      p_q            <= 22'd0;
      n_q            <= 22'd0;
      suma_q         <= 22'd0;
      predznak_q     <= 1'b0;
      idx_q          <= '0;
      izlaz_valid_q  <= 1'b0;
      uzorak_ready_q <= 1'b1;
      zauzet_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      uzorak_q       <= uzorak_d;
      neuron_q       <= neuron_d;
      k_q            <= k_d;
      adr_q          <= adr_d;
      mnoz_uzorak_q  <= mnoz_uzorak_d;
      p_q            <= p_d;
      n_q            <= n_d;
      suma_q         <= suma_d;
      predznak_q     <= predznak_d;
      idx_q          <= idx_d;
      izlaz_valid_q  <= izlaz_valid_d;
      uzorak_ready_q <= uzorak_ready_d;
      zauzet_q       <= zauzet_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    uzorak_d      = uzorak_q;
    neuron_d      = neuron_q;
    k_d           = k_q;
    adr_d         = adr_q;
    mnoz_uzorak_d = mnoz_uzorak_q;
    p_d           = p_q;
    n_d           = n_q;
    suma_d        = suma_q;
    predznak_d    = predznak_q;
    idx_d         = idx_q;
    izlaz_valid_d = izlaz_valid_q;

    case (state_q)
      MIR: begin
        izlaz_valid_d = 1'b0;
        if (uzorak_valid) begin
          uzorak_d = uzorak;
          neuron_d = '0;
          // ROM address must be on the bus during ADR so weight 0 lands in the first MAC cycle
          adr_d    = adr_baza('0);
          state_d  = ADR;
        end else begin
          state_d  = MIR;
        end
      end

      ADR: begin
        p_d           = 22'd0;
        n_d           = 22'd0;
        k_d           = '0;
        mnoz_uzorak_d = znacajka(uzorak_q, '0);
        adr_d         = adr_q + ADR_W'(1);
        state_d       = MAC;
      end

      MAC: begin
        if (rom_podatak[15]) begin
          n_d = n_q + 22'(mnoz_produkt);
        end else begin
          p_d = p_q + 22'(mnoz_produkt);
        end
        if (k_q == K_ZADNJI) begin
          state_d = USPOREDBA;
        end else begin
          k_d           = k_q + K_W'(1);
          mnoz_uzorak_d = znacajka(uzorak_q, k_q + K_W'(1));
          // Address runs one ahead of k; stop at the neuron's last weight
          if (k_q != K_PREDZAD) begin
            adr_d = adr_q + ADR_W'(1);
          end else begin
            adr_d = adr_q;
          end
          state_d = MAC;
        end
      end

      USPOREDBA: begin
        if (p_q > n_q) begin
          suma_d     = p_q - n_q;
          predznak_d = 1'b0;
        end else begin
          suma_d     = n_q - p_q;
          predznak_d = 1'b1;
        end
        idx_d         = neuron_q;
        izlaz_valid_d = 1'b1;
        state_d       = IZLAZ;
      end

      IZLAZ: begin
        if (izlaz_ready) begin
          izlaz_valid_d = 1'b0;
          if (neuron_q == N_ZADNJI) begin
            state_d = MIR;
          end else begin
            neuron_d = neuron_q + IDX_W'(1);
            adr_d    = adr_baza(neuron_q + IDX_W'(1));
            state_d  = ADR;
          end
        end else begin
          izlaz_valid_d = 1'b1;
          state_d       = IZLAZ;
        end
      end

      default: begin
        izlaz_valid_d = 1'b0;
        state_d       = MIR;
      end
    endcase

    uzorak_ready_d = (state_d == MIR);
    zauzet_d       = (state_d != MIR);
  end

  assign uzorak_ready = uzorak_ready_q;
  assign rom_adresa   = adr_q;
  assign mnoz_tezina  = rom_podatak;
  assign mnoz_uzorak  = mnoz_uzorak_q;
  assign suma         = suma_q;
  assign predznak     = predznak_q;
  assign neuron_idx   = idx_q;
  assign izlaz_valid  = izlaz_valid_q;
  assign zauzet       = zauzet_q;

endmodule

// File: tb/tb_neuron_mac_sekvencer.sv
// Self-checking bench for neuron_mac_sekvencer: ROM and multiplier stubs, sums predicted from
// the weight table and sample with plain arithmetic.
module tb_neuron_mac_sekvencer;
  localparam int NZ = 60;
  localparam int NN = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [959:0] uzorak;
  logic         uzorak_valid, uzorak_ready;
  logic [7:0]   rom_adresa;
  logic [15:0]  rom_podatak, mnoz_tezina, mnoz_uzorak, mnoz_produkt;
  logic [21:0]  suma;
  logic         predznak;
  logic [1:0]   neuron_idx;
  logic         izlaz_valid, izlaz_ready, zauzet;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:NN*NZ-1];
  bit          mode_real;
  logic [15:0] stub_val;

  always #5 clk = ~clk;

  neuron_mac_sekvencer #(.BROJ_ZNACAJKI(60), .BROJ_NEURONA(3), .ADR_W(8), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .uzorak(uzorak), .uzorak_valid(uzorak_valid),
    .uzorak_ready(uzorak_ready), .rom_adresa(rom_adresa), .rom_podatak(rom_podatak),
    .mnoz_tezina(mnoz_tezina), .mnoz_uzorak(mnoz_uzorak), .mnoz_produkt(mnoz_produkt),
    .suma(suma), .predznak(predznak), .neuron_idx(neuron_idx), .izlaz_valid(izlaz_valid),
    .izlaz_ready(izlaz_ready), .zauzet(zauzet)
  );

  always @(posedge clk) rom_podatak <= (rom_adresa < 8'd180) ? rom[rom_adresa] : 16'd0;

  function automatic logic [15:0] ref_mult(input logic [15:0] w, input logic [15:0] s);
    logic [30:0] p;
    p = {16'd0, w[14:0]} * {15'd0, s};
    return p[30:15];
  endfunction

  assign mnoz_produkt = mode_real ? ref_mult(mnoz_tezina, mnoz_uzorak) : stub_val;

  task automatic model(input logic [959:0] s, input int n, output logic [21:0] es, output logic ep);
    longint p_sum = 0;
    longint n_sum = 0;
    for (int k = 0; k < NZ; k++) begin
      logic [15:0] w, pr;
      w  = rom[n*NZ + k];
      pr = mode_real ? ref_mult(w, s[16*k +: 16]) : stub_val;
      if (w[15]) n_sum += pr; else p_sum += pr;
    end
    if (p_sum > n_sum) begin es = 22'(p_sum - n_sum); ep = 1'b0; end
    else begin es = 22'(n_sum - p_sum); ep = 1'b1; end
  endtask

  task automatic rand_sample(output logic [959:0] s);
    for (int i = 0; i < 30; i++) s[32*i +: 32] = $urandom();
  endtask

  // mode 0: random signs, 1: 24 positive / 36 negative, 2: all positive
  task automatic fill_rom(input int mode);
    for (int i = 0; i < NN*NZ; i++) begin
      logic [14:0] mag;
      logic        neg;
      mag = 15'($urandom_range(1, 32767));
      case (mode)
        1:       neg = ((i % NZ) % 5) >= 2;
        2:       neg = 1'b0;
        default: neg = 1'($urandom_range(0, 1));
      endcase
      rom[i] = {neg, mag};
    end
  endtask

  task automatic accept(input logic [959:0] s, output bit ok);
    int t = 0;
    uzorak = s;
    uzorak_valid = 1'b1;
    while (!uzorak_ready && t < 300) begin @(posedge clk); #1; t++; end
    ok = uzorak_ready;
    @(posedge clk); #1;
    uzorak_valid = 1'b0;
  endtask

  // cyc = 1 in the cycle right after the accept/handshake edge
  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 1;
    while (!izlaz_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    ok = izlaz_valid;
  endtask

  task automatic handshake();
    izlaz_ready = 1'b1;
    @(posedge clk); #1;
    izlaz_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uzorak_valid = 1'b0; izlaz_ready = 1'b0; uzorak = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uzorak_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", uzorak_ready); end
    checks++; if (izlaz_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", izlaz_valid); end
    checks++; if (suma !== 22'd0) begin errors++; $display("FAIL reset_suma: got %0d want 0", suma); end
    checks++; if (zauzet !== 1'b0) begin errors++; $display("FAIL reset_zauzet: got %b want 0", zauzet); end
    checks++; if ({predznak, neuron_idx, rom_adresa} !== 11'd0) begin
      errors++; $display("FAIL reset_misc: predznak %b idx %0d adr %0d want 0", predznak, neuron_idx, rom_adresa);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mixed_signs();
    logic [959:0] s;
    bit ok;
    int c;
    mode_real = 1'b0; stub_val = 16'h0001;
    fill_rom(1);
    rand_sample(s);
    accept(s, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t2_accept: ready never seen"); end
    checks++; if (rom_adresa !== 8'd0 || zauzet !== 1'b1 || uzorak_ready !== 1'b0) begin
      errors++; $display("FAIL t2_adr: adr %0d zauzet %b ready %b want 0 1 0", rom_adresa, zauzet, uzorak_ready);
    end
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      checks++; if (!ok || c != 63) begin errors++; $display("FAIL t2_latency n%0d: valid at cycle %0d (seen %b) want 63", n, c, ok); end
      checks++; if (suma !== 22'd12 || predznak !== 1'b1 || neuron_idx !== 2'(n)) begin
        errors++; $display("FAIL t2_result n%0d: suma %0d sign %b idx %0d want 12 1 %0d", n, suma, predznak, neuron_idx, n);
      end
      handshake();
      if (n < NN-1) begin
        checks++; if (rom_adresa !== 8'((n+1)*NZ)) begin errors++; $display("FAIL t2_base n%0d: adr %0d want %0d", n+1, rom_adresa, (n+1)*NZ); end
      end
    end
    checks++; if (uzorak_ready !== 1'b1 || zauzet !== 1'b0) begin
      errors++; $display("FAIL t2_idle: ready %b zauzet %b want 1 0", uzorak_ready, zauzet);
    end
  endtask

  task automatic test_max_sum();
    logic [959:0] s;
    bit ok;
    int c;
    mode_real = 1'b0; stub_val = 16'hFFFF;
    fill_rom(2);
    rand_sample(s);
    accept(s, ok);
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      checks++; if (!ok || suma !== 22'd3932100 || predznak !== 1'b0) begin
        errors++; $display("FAIL t3_max n%0d: suma %0d sign %b valid %b want 3932100 0 1", n, suma, predznak, ok);
      end
      handshake();
    end
  endtask

  task automatic test_zero_sample();
    bit ok;
    int c;
    mode_real = 1'b1;
    fill_rom(0);
    accept('0, ok);
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      checks++; if (!ok || suma !== 22'd0 || predznak !== 1'b1 || neuron_idx !== 2'(n)) begin
        errors++; $display("FAIL t4_zero n%0d: suma %0d sign %b idx %0d want 0 1 %0d", n, suma, predznak, neuron_idx, n);
      end
      handshake();
    end
  endtask

  task automatic test_stall();
    logic [959:0] a, b;
    logic [21:0]  es;
    logic         ep;
    bit ok, stable;
    int c;
    mode_real = 1'b1;
    fill_rom(0);
    rand_sample(a); rand_sample(b);
    accept(a, ok);
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      model(a, n, es, ep);
      checks++; if (!ok || suma !== es || predznak !== ep) begin
        errors++; $display("FAIL t5_a n%0d: suma %0d sign %b want %0d %b", n, suma, predznak, es, ep);
      end
      if (n == 0) begin
        uzorak = b; uzorak_valid = 1'b1;
        stable = 1'b1;
        repeat (10) begin
          @(posedge clk); #1;
          if (suma !== es || predznak !== ep || neuron_idx !== 2'd0 || rom_adresa !== 8'd59 ||
              uzorak_ready !== 1'b0 || izlaz_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL t5_stable: outputs moved during stall, want held"); end
      end
      handshake();
    end
    // b has been offered all along; it must be taken only now
    checks++; if (uzorak_ready !== 1'b1) begin errors++; $display("FAIL t5_ready: got %b want 1", uzorak_ready); end
    @(posedge clk); #1;
    uzorak_valid = 1'b0;
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      model(b, n, es, ep);
      checks++; if (!ok || c != 63 || suma !== es || predznak !== ep) begin
        errors++; $display("FAIL t5_b n%0d: cyc %0d suma %0d sign %b want 63 %0d %b", n, c, suma, predznak, es, ep);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [959:0] s;
    logic [21:0]  es;
    logic         ep;
    bit ok;
    int c;
    mode_real = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fill_rom(0);
      rand_sample(s);
      accept(s, ok);
      for (int n = 0; n < NN; n++) begin
        wait_valid(c, ok);
        model(s, n, es, ep);
        checks++; if (!ok || c != 63 || suma !== es || predznak !== ep || neuron_idx !== 2'(n)) begin
          errors++; $display("FAIL rnd r%0d n%0d: cyc %0d suma %0d sign %b idx %0d want 63 %0d %b %0d",
                             r, n, c, suma, predznak, neuron_idx, es, ep, n);
        end
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        handshake();
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [959:0] s;
    bit ok, seen;
    int c;
    mode_real = 1'b0; stub_val = 16'h0001;
    fill_rom(1);
    rand_sample(s);
    accept(s, ok);
    repeat (31) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (uzorak_ready !== 1'b1 || izlaz_valid !== 1'b0 || zauzet !== 1'b0 || suma !== 22'd0) begin
      errors++; $display("FAIL t6_abort: ready %b valid %b zauzet %b suma %0d want 1 0 0 0", uzorak_ready, izlaz_valid, zauzet, suma);
    end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (izlaz_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t6_no_result: izlaz_valid rose after abort, want none"); end
    rand_sample(s);
    accept(s, ok);
    for (int n = 0; n < NN; n++) begin
      wait_valid(c, ok);
      checks++; if (!ok || c != 63 || suma !== 22'd12 || predznak !== 1'b1) begin
        errors++; $display("FAIL t6_rerun n%0d: cyc %0d suma %0d sign %b want 63 12 1", n, c, suma, predznak);
      end
      handshake();
    end
  endtask

  initial begin
    mode_real = 1'b0; stub_val = 16'd0;
    test_reset();
    test_mixed_signs();
    test_max_sum();
    test_zero_sample();
    test_stall();
    test_random();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
